// File: rtl/l2_req_responder_pkg.sv
// Shared line/address/message types for the L2 request responder and its interface.
package l2_req_responder_pkg;

    localparam int WORD_BITS      = 64;
    localparam int WORDS_PER_LINE = 2;
    localparam int LINE_BITS      = WORD_BITS * WORDS_PER_LINE;
    localparam int ADDR_BITS      = 28;

    typedef logic [2:0]               coh_msg_t;
    typedef logic [1:0]               hprot_t;
    typedef logic [ADDR_BITS-1:0]     line_addr_t;
    typedef logic [LINE_BITS-1:0]     line_t;
    typedef logic [WORDS_PER_LINE-1:0] word_mask_t;
    typedef logic [3:0]               invack_cnt_t;

    localparam coh_msg_t REQ_V  = 3'd0;
    localparam coh_msg_t REQ_S  = 3'd1;
    localparam coh_msg_t REQ_O  = 3'd2;
    localparam coh_msg_t REQ_WT = 3'd3;
    localparam coh_msg_t REQ_WB = 3'd4;

    localparam coh_msg_t RSP_S      = 3'd0;
    localparam coh_msg_t RSP_O      = 3'd1;
    localparam coh_msg_t RSP_V      = 3'd2;
    localparam coh_msg_t RSP_WT     = 3'd3;
    localparam coh_msg_t RSP_WB_ACK = 3'd4;

    typedef struct packed {
        coh_msg_t   coh_msg;
        hprot_t     hprot;
        line_addr_t addr;
        line_t      line;
        word_mask_t word_mask;
    } l2_req_out_t;

    typedef struct packed {
        coh_msg_t    coh_msg;
        line_addr_t  addr;
        line_t       line;
        word_mask_t  word_mask;
        invack_cnt_t invack_cnt;
    } l2_rsp_in_t;

endpackage

// File: rtl/l2_req_responder_if.sv
// Request/response channel pair between an L2 cache (master) and its memory-side responder (slave).
interface l2_req_responder_if;
    import l2_req_responder_pkg::*;

    logic        l2_req_out_valid;
    logic        l2_req_out_ready;
    l2_req_out_t l2_req_out;
    logic        l2_rsp_in_valid;
    logic        l2_rsp_in_ready;
    l2_rsp_in_t  l2_rsp_in;

    modport master (
        output l2_req_out_valid, l2_req_out, l2_rsp_in_ready,
        input  l2_req_out_ready, l2_rsp_in_valid, l2_rsp_in
    );

    modport slave (
        input  l2_req_out_valid, l2_req_out, l2_rsp_in_ready,
        output l2_req_out_ready, l2_rsp_in_valid, l2_rsp_in
    );

endinterface

// File: rtl/l2_req_responder.sv
// Purpose: fixed-latency memory model answering L2 requests from a small line store (L2_RESP_STALL_INJECT_EN adds LFSR ready stalls).
// Latency: response valid exactly LATENCY cycles after the accepting edge; one request outstanding.
// Backpressure: response payload held until l2_rsp_in_ready; no new request accepted until then.
module l2_req_responder
    import l2_req_responder_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int MEM_LINES = 16
) (
    input logic                clk,
    input logic                rst,
    l2_req_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(MEM_LINES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    coh_msg_t    req_msg_q, req_msg_d;
    line_addr_t  req_addr_q, req_addr_d;
    line_t       req_line_q, req_line_d;
    word_mask_t  req_mask_q, req_mask_d;
    l2_rsp_in_t  rsp_q, rsp_d;
    line_t       mem_q [MEM_LINES];
    line_t       mem_d [MEM_LINES];

    logic              stall;
    logic              req_rdy;
    logic [IDX_W-1:0]  idx;
    line_t             rd_line;
    line_t             wr_line;
    logic              wr_en;
    l2_rsp_in_t        rsp_build;
    logic              unused_hprot;

    assign unused_hprot = ^bus.l2_req_out.hprot;

`ifdef L2_RESP_STALL_INJECT_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci form of x^8+x^6+x^5+x^4+1
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= 8'hA5;
        else     lfsr_q <= lfsr_d;
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // Ready is forced low while reset is held, not just after the state flop clears.
    assign req_rdy = (state_q == IDLE) && !rst && !stall;

    assign bus.l2_req_out_ready = req_rdy;
    assign bus.l2_rsp_in_valid  = (state_q == RESP);
    assign bus.l2_rsp_in        = rsp_q;

    assign idx = req_addr_q[IDX_W-1:0];

    always_comb begin
        rd_line = mem_q[idx];
        wr_line = rd_line;
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
            if (req_mask_q[w]) wr_line[w*WORD_BITS +: WORD_BITS] = req_line_q[w*WORD_BITS +: WORD_BITS];
        end
        wr_en               = 1'b0;
        rsp_build           = '0;
        rsp_build.addr      = req_addr_q;
        rsp_build.word_mask = req_mask_q;
        case (req_msg_q)
            REQ_V:  begin rsp_build.coh_msg = RSP_V;  rsp_build.line = rd_line; end
            REQ_S:  begin rsp_build.coh_msg = RSP_S;  rsp_build.line = rd_line; end
            REQ_O:  begin rsp_build.coh_msg = RSP_O;  rsp_build.line = rd_line; end
            REQ_WT: begin rsp_build.coh_msg = RSP_WT;     wr_en = 1'b1; end
            REQ_WB: begin rsp_build.coh_msg = RSP_WB_ACK; wr_en = 1'b1; end
            default: begin rsp_build.coh_msg = RSP_V; rsp_build.line = '1; end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_msg_d  = req_msg_q;
        req_addr_d = req_addr_q;
        req_line_d = req_line_q;
        req_mask_d = req_mask_q;
        rsp_d      = rsp_q;
        mem_d      = mem_q;
        case (state_q)
            IDLE: begin
                if (bus.l2_req_out_valid && req_rdy) begin
                    req_msg_d  = bus.l2_req_out.coh_msg;
                    req_addr_d = bus.l2_req_out.addr;
                    req_line_d = bus.l2_req_out.line;
                    req_mask_d = bus.l2_req_out.word_mask;
                    cnt_d      = 4'(LATENCY - 1);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    rsp_d   = rsp_build;
                    state_d = RESP;
                    if (wr_en) mem_d[idx] = wr_line;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.l2_rsp_in_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_msg_q  <= '0;
            req_addr_q <= '0;
            req_line_q <= '0;
            req_mask_q <= '0;
            rsp_q      <= '0;
            for (int i = 0; i < MEM_LINES; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_msg_q  <= req_msg_d;
            req_addr_q <= req_addr_d;
            req_line_q <= req_line_d;
            req_mask_q <= req_mask_d;
            rsp_q      <= rsp_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_l2_req_responder.sv
// Self-checking bench for l2_req_responder: directed vector table, stall/reset sequences, random scoreboard run.
module tb_l2_req_responder;
    import l2_req_responder_pkg::*;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_req_responder_if bus();

    l2_req_responder #(.LATENCY(LAT), .MEM_LINES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    l2_rsp_in_t exp_q[$];
    line_t model_mem[16];
    logic prev_vld = 1'b0;
    bit tog_stop = 1'b0;

    typedef struct {
        coh_msg_t   msg;
        line_addr_t addr;
        line_t      line;
        word_mask_t mask;
        coh_msg_t   e_msg;
        line_t      e_line;
    } vec_t;
    vec_t tbl[11];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic l2_rsp_in_t model(input l2_req_out_t r);
        l2_rsp_in_t e;
        int i;
        line_t cur;
        i = int'(r.addr[3:0]);
        cur = model_mem[i];
        e = '0;
        e.addr = r.addr;
        e.word_mask = r.word_mask;
        case (r.coh_msg)
            REQ_V: begin e.coh_msg = RSP_V; e.line = cur; end
            REQ_S: begin e.coh_msg = RSP_S; e.line = cur; end
            REQ_O: begin e.coh_msg = RSP_O; e.line = cur; end
            REQ_WT, REQ_WB: begin
                for (int w = 0; w < WORDS_PER_LINE; w++)
                    if (r.word_mask[w]) cur[w*WORD_BITS +: WORD_BITS] = r.line[w*WORD_BITS +: WORD_BITS];
                model_mem[i] = cur;
                e.coh_msg = (r.coh_msg == REQ_WT) ? RSP_WT : RSP_WB_ACK;
            end
            default: begin e.coh_msg = RSP_V; e.line = '1; end
        endcase
        return e;
    endfunction

    // Response monitor: checks latency on each rising valid, pops the scoreboard on handshakes.
    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (bus.l2_rsp_in_valid && !prev_vld) check("latency", 256'(cyc - acc_cyc), 256'(LAT));
            if (bus.l2_rsp_in_valid && bus.l2_rsp_in_ready) begin
                check("rsp_expected", 256'(exp_q.size() != 0), 256'(1));
                if (exp_q.size() != 0) check("rsp", 256'(bus.l2_rsp_in), 256'(exp_q.pop_front()));
            end
            prev_vld = bus.l2_rsp_in_valid && !bus.l2_rsp_in_ready;
        end
    end

`ifdef L2_RESP_STALL_INJECT_EN
    logic [7:0] tb_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) tb_lfsr = 8'hA5;
        else     tb_lfsr = {tb_lfsr[6:0], tb_lfsr[7] ^ tb_lfsr[5] ^ tb_lfsr[4] ^ tb_lfsr[3]};
    end
    always @(negedge clk) begin
        if (!rst && bus.l2_req_out_ready) check("lfsr_gate", 256'(tb_lfsr[0]), 256'(0));
    end
`endif

    task automatic send(input l2_req_out_t r, input bit push, input l2_rsp_in_t e);
        int n;
        n = 0;
        @(negedge clk);
        bus.l2_req_out_valid = 1'b1;
        bus.l2_req_out = r;
        while (!bus.l2_req_out_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.l2_req_out_ready) begin
            check("accept_timeout", 256'(bus.l2_req_out_ready), 256'(1));
            bus.l2_req_out_valid = 1'b0;
        end else begin
            acc_cyc = cyc + 1;
            if (push) exp_q.push_back(e);
            @(posedge clk);
            #1 bus.l2_req_out_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", 256'(exp_q.size()), 256'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        l2_req_out_t r;
        l2_rsp_in_t e;
        l2_rsp_in_t snap;
        bit seen;
        int n;

        tbl[0]  = '{REQ_V,  28'h3,  128'h0, 2'b11, RSP_V, 128'h0};
        tbl[1]  = '{REQ_WT, 28'h5,  {64'h1111111111111111, 64'h2222222222222222}, 2'b01, RSP_WT, 128'h0};
        tbl[2]  = '{REQ_V,  28'h5,  128'h0, 2'b11, RSP_V, {64'h0, 64'h2222222222222222}};
        tbl[3]  = '{REQ_WB, 28'h12, {64'hAAAA0000AAAA0001, 64'hBBBB0000BBBB0002}, 2'b11, RSP_WB_ACK, 128'h0};
        tbl[4]  = '{REQ_V,  28'h02, 128'h0, 2'b11, RSP_V, {64'hAAAA0000AAAA0001, 64'hBBBB0000BBBB0002}};
        tbl[5]  = '{REQ_S,  28'h2,  128'h0, 2'b10, RSP_S, {64'hAAAA0000AAAA0001, 64'hBBBB0000BBBB0002}};
        tbl[6]  = '{REQ_O,  28'h22, 128'h0, 2'b01, RSP_O, {64'hAAAA0000AAAA0001, 64'hBBBB0000BBBB0002}};
        tbl[7]  = '{REQ_WT, 28'h2,  {128{1'b1}}, 2'b00, RSP_WT, 128'h0};
        tbl[8]  = '{REQ_V,  28'h2,  128'h0, 2'b11, RSP_V, {64'hAAAA0000AAAA0001, 64'hBBBB0000BBBB0002}};
        tbl[9]  = '{3'd7,   28'h5,  128'h0, 2'b10, RSP_V, {128{1'b1}}};
        tbl[10] = '{REQ_V,  28'h5,  128'h0, 2'b01, RSP_V, {64'h0, 64'h2222222222222222}};

        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        bus.l2_req_out_valid = 1'b0;
        bus.l2_req_out = '0;
        bus.l2_rsp_in_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", 256'(bus.l2_req_out_ready), 256'(0));
        check("rst_rsp_valid", 256'(bus.l2_rsp_in_valid), 256'(0));
        check("rst_rsp_payload", 256'(bus.l2_rsp_in), 256'(0));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 256'(bus.l2_req_out_ready), 256'(1));

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            r = '0;
            r.coh_msg = tbl[i].msg;
            r.addr = tbl[i].addr;
            r.line = tbl[i].line;
            r.word_mask = tbl[i].mask;
            e = '0;
            e.coh_msg = tbl[i].e_msg;
            e.addr = tbl[i].addr;
            e.line = tbl[i].e_line;
            e.word_mask = tbl[i].mask;
            void'(model(r));
            send(r, 1'b1, e);
        end
        drain();

        // Held response: payload stable, no request accepted
        @(posedge clk);
        #1 bus.l2_rsp_in_ready = 1'b0;
        r = '0;
        r.coh_msg = REQ_V;
        r.addr = 28'h2;
        r.word_mask = 2'b11;
        send(r, 1'b1, model(r));
        n = 0;
        while (!bus.l2_rsp_in_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid_seen", 256'(bus.l2_rsp_in_valid), 256'(1));
        snap = bus.l2_rsp_in;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_valid", 256'(bus.l2_rsp_in_valid), 256'(1));
            check("stall_payload", 256'(bus.l2_rsp_in), 256'(snap));
            check("stall_req_ready", 256'(bus.l2_req_out_ready), 256'(0));
        end
        @(posedge clk);
        #1 bus.l2_rsp_in_ready = 1'b1;
        drain();

        // Reset during WAIT drops the request and clears the store
        r = '0;
        r.coh_msg = REQ_WT;
        r.addr = 28'h5;
        r.line = '1;
        r.word_mask = 2'b11;
        send(r, 1'b0, '0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        #1;
        check("midrst_req_ready", 256'(bus.l2_req_out_ready), 256'(0));
        check("midrst_rsp_valid", 256'(bus.l2_rsp_in_valid), 256'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", 256'(bus.l2_req_out_ready), 256'(1));
        seen = 1'b0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (bus.l2_rsp_in_valid) seen = 1'b1;
        end
        check("midrst_no_response", 256'(seen), 256'(0));
        r = '0;
        r.coh_msg = REQ_V;
        r.addr = 28'h5;
        r.word_mask = 2'b11;
        send(r, 1'b1, model(r));
        r.addr = 28'h12;
        send(r, 1'b1, model(r));
        drain();

        // Random back-to-back traffic with random response backpressure
        fork
            begin
                while (!tog_stop) begin
                    @(posedge clk);
                    #1 bus.l2_rsp_in_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 100; i++) begin
                    r.coh_msg = 3'($urandom_range(0, 7));
                    r.hprot = 2'($urandom_range(0, 3));
                    r.addr = 28'($urandom_range(0, 63));
                    r.line = {$urandom, $urandom, $urandom, $urandom};
                    r.word_mask = 2'($urandom_range(0, 3));
                    send(r, 1'b1, model(r));
                end
                tog_stop = 1'b1;
            end
        join
        @(posedge clk);
        #1 bus.l2_rsp_in_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
